gen_read_logic: RTL and testbench
=================================

// Module: gen_read_logic
// PURPOSE
//  Readout side of the ADC capture buffer. Once the capture memory holds a full frame (wr_done=1),
//  a register-triggered start sweeps read addresses through the capture RAM. The returned words are
//  streamed out on a valid/ready interface toward the packet controller. A small credit-managed
//  output FIFO absorbs the RAM read latency and downstream backpressure without losing a word.
// PARAMETERS
//  AW       15  capture RAM address width; the full frame is 2**AW words
//  DW       32  capture RAM data width
//  MEM_LAT  1   RAM read latency in cycles, from mem_rd_en to mem_rdata valid; supported values 1..2
//  FIFO_D   4   output FIFO depth, power of 2, must be >= MEM_LAT+2
// PORTS
//  clk              in   1   capture clock
//  rst              in   1   asynchronous reset, active-high
//  rf_capture_start in   1   pulse: new capture begins; aborts any readout and clears rd_done
//  wr_done          in   1   level from the write side: frame complete
//  rf_read_start    in   1   pulse: start readout
//  mem_rd_en        out  1   RAM read strobe
//  raddr            out  AW  RAM read address
//  mem_rdata        in   DW  RAM read data, valid MEM_LAT cycles after mem_rd_en
//  rd_data          out  DW  stream data
//  rd_valid         out  1   stream valid
//  rd_ready         in   1   stream ready; a beat transfers when rd_valid&rd_ready
//  rd_last          out  1   high with the final beat of the frame
//  rd_busy          out  1   high in READ or DRAIN
//  rd_done          out  1   sticky: frame fully delivered
//  rd_start_err     out  1   one-cycle pulse: rf_read_start rejected
// BEHAVIOUR
//  - Reset values: all outputs 0, state=IDLE, FIFO empty, in-flight count 0.
//  - FSM: IDLE -> READ on rf_read_start & wr_done & !rf_capture_start. READ -> DRAIN the cycle after the
//    last address issues. DRAIN -> DONE when the FIFO is empty and no reads are in flight. DONE -> READ
//    on a new valid rf_read_start, which re-reads the same frame.
//  - Start in IDLE/DONE with wr_done=0: ignored, rd_start_err=1 for 1 cycle. Start in READ/DRAIN: ignored, no error.
//  - Issue: in READ, mem_rd_en=1 when (fifo_count + inflight) < FIFO_D. raddr holds the address being
//    issued and advances by 1 after each issue. It wraps modulo 2**AW, with no saturation.
//  - Return: the word is written to the FIFO exactly MEM_LAT cycles after its mem_rd_en, tracked by a
//    MEM_LAT-deep shift tag. The credit rule guarantees the FIFO never overflows.
//  - Output: the FIFO head drives rd_data/rd_valid. Data and rd_last stay stable while rd_valid & !rd_ready.
//    FIFO push and pop in the same cycle are both allowed, and the count is unchanged.
//  - rd_last is carried as a FIFO sideband bit, set on the word fetched from the final address.
//    Exactly one rd_last per readout.
//  - First-beat latency with rd_ready=1: rd_valid rises MEM_LAT+1 cycles after rf_read_start.
//    Sustained rate is 1 beat/cycle.
//  - rd_done rises 1 cycle after the rd_last beat transfers. It clears on rf_capture_start or a
//    valid rf_read_start.
//  - rf_capture_start, in any state: next cycle state=IDLE, mem_rd_en=0, FIFO flushed, in-flight
//    returns discarded, rd_valid=0, rd_done=0, rd_busy=0. It wins over a simultaneous rf_read_start.
//  - rst asserted mid-readout: immediate return to the reset values. There is no partial-frame resume.
// CONFIGURATION
//  RD_RANGE_EN defined:
//    - Adds the inputs rf_rd_base[AW-1:0] and rf_rd_len[AW-1:0]. The readout covers rf_rd_len+1 words
//      starting at rf_rd_base, with the address wrapping modulo 2**AW.
//    - Both inputs are sampled on the accepted start and held internally for the rest of the readout.
//  RD_RANGE_EN undefined:
//    - No such ports. The base is 0 and the frame is always 2**AW words, 0..2**AW-1.
// TESTING
//  1. Full frame, ram[a]=a, rd_ready=1 -> 32768 beats with data 0..32767 in order, rd_last only on
//     32767, rd_done=1 the next cycle.
//  2. Random rd_ready (~50%) -> identical sequence, no drops or duplicates, stable data while stalled,
//     and at most 4 words ever held in the FIFO.
//  3. rf_read_start while wr_done=0 -> rd_start_err pulse of 1 cycle, no mem_rd_en, state stays IDLE.
//  4. rf_capture_start after 100 beats with rd_ready=0 -> rd_valid=0 and rd_busy=0 the next cycle.
//     In-flight data never appears, and rd_done=0.
//  5. RD_RANGE_EN with base=0x7FFE, len=3 -> raddr sequence 7FFE,7FFF,0000,0001, 4 beats, rd_last on
//     the beat carrying address 0001.
//  6. rst pulse mid-READ -> all outputs 0 asynchronously. A new start after release re-reads from address 0.

Source files
------------

// File: rtl/gen_read_logic.sv
// Capture-buffer readout: sweeps the capture RAM and streams words out through a credit-managed FIFO.
// Optional RD_RANGE_EN adds rf_rd_base/rf_rd_len to read a wrapped sub-range instead of the full frame.
module gen_read_logic #(
  parameter int AW      = 15,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1,
  parameter int FIFO_D  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rf_capture_start,
  input  logic          wr_done,
  input  logic          rf_read_start,
`ifdef RD_RANGE_EN
  input  logic [AW-1:0] rf_rd_base,
  input  logic [AW-1:0] rf_rd_len,
`endif
  output logic          mem_rd_en,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic          rd_busy,
  output logic          rd_done,
  output logic          rd_start_err
);
  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic              start_req, start_ok, start_bad;
  logic [AW-1:0]     start_base, len_q, cnt;
  logic              issue_last, credit_ok, push, pop;
  logic [MEM_LAT-1:0] tag_vld_p, tag_last_p;
  logic [CW-1:0]     inflight, fifo_count;
  logic [CW:0]       occ;
  logic [PW-1:0]     wptr, rptr;
  logic [DW-1:0]     fifo_data [FIFO_D];
  logic              fifo_last [FIFO_D];

  assign start_req = rf_read_start & ~rf_capture_start & ((state == IDLE) | (state == DONE));
  assign start_ok  = start_req & wr_done;
  assign start_bad = start_req & ~wr_done;

`ifdef RD_RANGE_EN
  // Length is latched at the accepted start; the base only seeds raddr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           len_q <= '0;
    else if (start_ok) len_q <= rf_rd_len;
  end
  assign start_base = rf_rd_base;
`else
  assign len_q      = '1;
  assign start_base = '0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(tag_vld_p[i]);
  end

  assign occ        = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok  = occ < (CW+1)'(FIFO_D);
  assign issue_last = (cnt == len_q);
  assign mem_rd_en  = (state == READ) & credit_ok;
  assign rd_busy    = (state == READ) | (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = READ;
      READ:       if (mem_rd_en & issue_last) state_nxt = DRAIN;
      DRAIN:      if ((fifo_count == '0) & (inflight == '0)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (rf_capture_start) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr <= '0;
      cnt   <= '0;
    end else if (start_ok) begin
      raddr <= start_base;
      cnt   <= '0;
    end else if (mem_rd_en) begin
      raddr <= raddr + 1'b1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Stage p0..pN: issue tags ride alongside the RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p  <= '0;
      tag_last_p <= '0;
    end else if (rf_capture_start) begin
      tag_vld_p  <= '0;
      tag_last_p <= '0;
    end else begin
      tag_vld_p[0]  <= mem_rd_en;
      tag_last_p[0] <= mem_rd_en & issue_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_p[i]  <= tag_vld_p[i-1];
        tag_last_p[i] <= tag_last_p[i-1];
      end
    end
  end

  // Output FIFO stage
  assign push = tag_vld_p[MEM_LAT-1];
  assign pop  = rd_valid & rd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= mem_rdata;
      fifo_last[wptr] <= tag_last_p[MEM_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else if (rf_capture_start) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push & ~pop)      fifo_count <= fifo_count + 1'b1;
      else if (~push & pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? fifo_data[rptr] : '0;
  assign rd_last  = rd_valid & fifo_last[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done      <= 1'b0;
      rd_start_err <= 1'b0;
    end else begin
      rd_start_err <= start_bad;
      if (rf_capture_start | start_ok) rd_done <= 1'b0;
      else if (pop & rd_last)          rd_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gen_read_logic.sv
// Scoreboard bench for gen_read_logic: expected words queued at start, checked as beats transfer.
module tb_gen_read_logic;
  localparam int AW = 15, DW = 32, MEM_LAT = 1, FIFO_D = 4;
  localparam int FRAME = 1 << AW;

  logic clk = 0, rst = 1;
  logic rf_capture_start = 0, wr_done = 0, rf_read_start = 0, rd_ready = 0;
  logic mem_rd_en, rd_valid, rd_last, rd_busy, rd_done, rd_start_err;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_rdata = '0, rd_data;
`ifdef RD_RANGE_EN
  logic [AW-1:0] rf_rd_base = '0, rf_rd_len = '1;
`endif

  int n_cmp = 0, n_err = 0, nbeats = 0, osd = 0;
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  logic [AW-1:0] exp_a[$];
  bit            prev_stall = 0, done_chk = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  gen_read_logic #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst(rst), .rf_capture_start(rf_capture_start), .wr_done(wr_done),
    .rf_read_start(rf_read_start),
`ifdef RD_RANGE_EN
    .rf_rd_base(rf_rd_base), .rf_rd_len(rf_rd_len),
`endif
    .mem_rd_en(mem_rd_en), .raddr(raddr), .mem_rdata(mem_rdata), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_start_err(rd_start_err));

  // Capture RAM model, ram[a] = a, one cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rdata <= DW'(raddr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(DW'((base + i) % FRAME));
      exp_l.push_back(i == n - 1);
    end
  endtask

  task automatic flush_q();
    exp_d.delete();
    exp_l.delete();
    exp_a.delete();
  endtask

  task automatic pulse_start();
    rf_read_start = 1;
    step();
    rf_read_start = 0;
  endtask

  task automatic pulse_capture();
    rf_capture_start = 1;
    step();
    rf_capture_start = 0;
    flush_q();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_rd_busy"}, rd_busy, 0);
    chk({tag, "_rd_done"}, rd_done, 0);
    chk({tag, "_rd_start_err"}, rd_start_err, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!rd_done && k < budget) begin
      step();
      k++;
    end
    chk(tag, rd_done, 1);
  endtask

  // Stream monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      osd = 0;
      prev_stall = 0;
      done_chk = 0;
    end else begin
      if (done_chk) begin
        chk("rd_done_after_last", rd_done, 1);
        done_chk = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", rd_data, prev_data);
        chk("stall_last", rd_last, prev_last);
      end
      if (mem_rd_en) begin
        osd++;
        if (exp_a.size() != 0) chk("raddr_seq", raddr, exp_a.pop_front());
      end
      if (rd_valid && rd_ready) begin
        nbeats++;
        osd--;
        n_cmp++;
        assert (exp_d.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat observed=%0h expected=none", rd_data);
        end
        if (exp_d.size() != 0) begin
          chk("beat_data", rd_data, exp_d.pop_front());
          chk("beat_last", rd_last, exp_l.pop_front());
        end
        if (rd_last) begin
          chk("rd_done_before_last", rd_done, 0);
          done_chk = 1;
        end
      end
      n_cmp++;
      assert (osd <= FIFO_D) else begin
        n_err++;
        $error("FAIL outstanding observed=%0d expected<=%0d", osd, FIFO_D);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
      if (rf_capture_start) begin
        osd = 0;
        prev_stall = 0;
        done_chk = 0;
      end
    end
  end

  initial begin
    int b0, k;
    // Reset values
    repeat (3) step();
    chk_all_zero("reset");
    rst = 0;
    step();

    // Start while frame not written: error pulse only
    wr_done = 0;
    pulse_start();
    chk("t3_err_pulse", rd_start_err, 1);
    chk("t3_no_rd_en", mem_rd_en, 0);
    chk("t3_idle", rd_busy, 0);
    step();
    chk("t3_err_clear", rd_start_err, 0);
    chk("t3_still_idle", rd_busy, 0);
    chk("t3_no_rd_en2", mem_rd_en, 0);

    // Full frame at full rate
    wr_done  = 1;
    rd_ready = 1;
    push_frame(0, FRAME);
    pulse_start();
    chk("t1_busy", rd_busy, 1);
    chk("t1_first_issue", mem_rd_en, 1);
    chk("t1_first_addr", raddr, 0);
    chk("t1_valid_e0", rd_valid, 0);
    step();
    chk("t1_valid_e1", rd_valid, 0);
    step();
    chk("t1_valid_e2", rd_valid, 1);
    chk("t1_first_data", rd_data, 0);
    wait_done("t1_done", FRAME + 100);
    chk("t1_all_delivered", exp_d.size(), 0);
    step();
    step();
    chk("t1_not_busy", rd_busy, 0);
    chk("t1_done_sticky", rd_done, 1);
    chk("t1_valid_low", rd_valid, 0);

    // Re-read from DONE with random backpressure, then abort
    push_frame(0, FRAME);
    pulse_start();
    chk("t2_done_cleared", rd_done, 0);
    chk("t2_busy", rd_busy, 1);
    for (int i = 0; i < 4000; i++) begin
      rd_ready = 1'($urandom_range(0, 1));
      step();
    end
    pulse_capture();
    chk("t2_abort_valid", rd_valid, 0);
    chk("t2_abort_busy", rd_busy, 0);
    chk("t2_abort_rd_en", mem_rd_en, 0);
    rd_ready = 1;
    repeat (8) step();
    chk("t2_quiet", rd_valid, 0);

    // Capture after 100 beats with the sink stalled
    push_frame(0, FRAME);
    b0 = nbeats;
    pulse_start();
    k = 0;
    while (nbeats - b0 < 100 && k < 400) begin
      step();
      k++;
    end
    chk("t4_reached_100", (nbeats - b0) >= 100, 1);
    rd_ready = 0;
    repeat (5) step();
    chk("t4_stalled_valid", rd_valid, 1);
    pulse_capture();
    chk("t4_valid", rd_valid, 0);
    chk("t4_busy", rd_busy, 0);
    chk("t4_done", rd_done, 0);
    rd_ready = 1;
    repeat (8) step();
    chk("t4_no_inflight", rd_valid, 0);

    // Asynchronous reset mid-readout
    push_frame(0, FRAME);
    pulse_start();
    repeat (50) step();
    #1 rst = 1;
    #1 chk_all_zero("t6_async");
    flush_q();
    step();
    step();
    rst = 0;
    step();
    push_frame(0, FRAME);
    b0 = nbeats;
    pulse_start();
    chk("t6_restart_addr", raddr, 0);
    chk("t6_restart_issue", mem_rd_en, 1);
    repeat (200) step();
    chk("t6_progress", (nbeats - b0) > 150, 1);
    pulse_capture();
    chk("t6_abort_busy", rd_busy, 0);

`ifdef RD_RANGE_EN
    // Wrapped sub-range readout
    rf_rd_base = 15'h7FFE;
    rf_rd_len  = 15'd3;
    exp_a.push_back(15'h7FFE); exp_a.push_back(15'h7FFF);
    exp_a.push_back(15'h0000); exp_a.push_back(15'h0001);
    exp_d.push_back(32'h7FFE); exp_d.push_back(32'h7FFF);
    exp_d.push_back(32'h0000); exp_d.push_back(32'h0001);
    exp_l.push_back(0); exp_l.push_back(0); exp_l.push_back(0); exp_l.push_back(1);
    pulse_start();
    rf_rd_base = '0;
    rf_rd_len  = '1;
    wait_done("t5_done", 100);
    chk("t5_addrs_used", exp_a.size(), 0);
    chk("t5_beats_used", exp_d.size(), 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
